srm_fsm_ctrl: RTL and testbench
===============================

Name: srm_fsm_ctrl

Overview:
- Moore-style sequencing FSM for the Simple RISC Machine datapath.
- Accepts a start strobe and the opcode/op fields from the instruction decoder.
- Steps the register file, A/B/C load enables, status load and mux selects through one multi-cycle instruction, then returns to idle.
- Sits between the instruction register/decoder and the datapath. It drives the decoder's nsel input and the datapath's control inputs.

Parameters:
- NSEL_RN, 3'b001, nsel one-hot code selecting the Rn field.
- NSEL_RD, 3'b010, nsel one-hot code selecting the Rd field.
- NSEL_RM, 3'b100, nsel one-hot code selecting the Rm field.

Ports:
- clk     in   1  rising-edge clock.
- reset   in   1  synchronous, active-high reset.
- s       in   1  start strobe; sampled only in WAIT.
- opcode  in   3  instruction bits [15:13] from the decoder.
- op      in   2  instruction bits [12:11] from the decoder (ALUop for opcode 101).
- w       out  1  high while in WAIT (ready for a new instruction).
- nsel    out  3  register-field select to the decoder; 000 when no register access.
- loada   out  1  load enable, A register.
- loadb   out  1  load enable, B register.
- loadc   out  1  load enable, C register.
- loads   out  1  load enable, status register.
- asel    out  1  1 forces ALU A input to 0.
- bsel    out  1  1 selects sximm5 for B (held 0 in this revision).
- vsel    out  2  writeback select: 00 C, 10 sximm8; 01 and 11 are reserved, never driven.
- write   out  1  register-file write enable.
- err     out  1  one-cycle pulse in DECODE on an undefined encoding.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high.
  - Reset forces state WAIT and clears the latched opcode/op to 0.
  - Output values after reset: w=1; all other outputs 0; nsel=000.
  - Reset asserted mid-instruction aborts it at the next edge. No write occurs in the reset cycle, because reset has priority over the state decode.
- Latching:
  - On the edge where state=WAIT and s=1, opcode/op are latched internally.
  - All later decisions use the latched copy, so input changes mid-instruction have no effect.
  - s is ignored in every state other than WAIT.
- Outputs are combinational from state and the latched fields only. There is no dependence on live inputs.
- States and outputs (unlisted outputs are 0):
  - WAIT: w=1. s=1 → DECODE; otherwise stay.
  - DECODE: no enables. Next state by latched {opcode,op}:
    - 110/10 (MOV imm) → WRITE_IMM.
    - 110/00 (MOV reg) → GET_B.
    - 101/11 (MVN) → GET_B.
    - 101/00, 101/01, 101/10 (ADD, CMP, AND) → GET_A.
    - Anything else → WAIT with err=1 for this cycle.
  - WRITE_IMM: nsel=NSEL_RN, vsel=10, write=1 → WAIT.
  - GET_A: nsel=NSEL_RN, loada=1 → GET_B.
  - GET_B: nsel=NSEL_RM, loadb=1 → ALU.
  - ALU:
    - asel=1 for MOV reg and MVN; asel=0 otherwise.
    - CMP: loads=1, loadc=0 → WAIT.
    - All others: loadc=1 → WRITE_REG.
  - WRITE_REG: nsel=NSEL_RD, vsel=00, write=1 → WAIT.
- Latency, counted in edges from the s-sampling edge until w=1 again:
  - MOV imm: 3.
  - CMP: 5.
  - MOV reg, MVN: 5.
  - ADD, AND: 6.
  - Undefined encoding: 2.
- Back-to-back: s held high re-enters DECODE on the first edge after returning to WAIT. w is high for exactly one cycle in that case.
- Invariants:
  - write and any load enable are never high together.
  - At most one of loada, loadb, loadc, loads is high in a cycle.
  - nsel is always one-hot or 000.
  - The state register is one-hot or binary; unreachable encodings recover to WAIT on the next edge.

Test Plan:
- Reset mid-instruction: reset=1 for 1 cycle while in GET_B → next cycle w=1, all enables 0, nsel=000; no write pulse observed.
- MOV R5,#85 (opcode=110, op=10), s pulse → DECODE, then WRITE_IMM with nsel=001, vsel=10, write=1; w=1 on the 3rd edge.
- ADD (opcode=101, op=00) → in order: loada with nsel=001, loadb with nsel=100, loadc with asel=0, write with nsel=010 and vsel=00; w back on the 6th edge.
- CMP (opcode=101, op=01) → GET_A, GET_B, then ALU with loads=1 and loadc=0; never reaches WRITE_REG, write stays 0; w back on the 5th edge.
- MVN (opcode=101, op=11) and MOV reg (opcode=110, op=00) → GET_A skipped; ALU cycle has asel=1 and loadc=1; write with nsel=010.
- Undefined opcode=111 → err=1 for exactly 1 cycle in DECODE, no enables, w=1 on the 2nd edge. Change opcode to 000 during an ADD after the s edge → sequence unchanged.

Source files
------------

// File: rtl/srm_fsm_ctrl.sv
// srm_fsm_ctrl: Moore sequencing FSM for the Simple RISC Machine datapath.
// Takes a start strobe plus the decoder's opcode/op fields and walks the
// register file, A/B/C/status load enables and mux selects through one
// multi-cycle instruction before returning to WAIT.
// The control outputs are registered. They are decoded from the next state
// and the next latched fields, so their timing matches a plain Moore decode
// of the current state, and they do not glitch.
module srm_fsm_ctrl #(
    parameter logic [2:0] NSEL_RN = 3'b001,
    parameter logic [2:0] NSEL_RD = 3'b010,
    parameter logic [2:0] NSEL_RM = 3'b100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       err
);

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_ALU       = 3'd5,
        S_WRITE_REG = 3'd6
    } state_t;

    typedef struct packed {
        logic       w;
        logic [2:0] nsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] vsel;
        logic       write;
        logic       err;
    } ctrl_t;

    state_t     state_q, state_d;
    logic [2:0] opc_q, opc_d;
    logic [1:0] op_q, op_d;
    ctrl_t      ctrl_q;

    // CMP only updates status; it never writes back.
    function automatic logic is_cmp(input logic [2:0] opc, input logic [1:0] opf);
        return (opc == 3'b101) && (opf == 2'b01);
    endfunction

    // MOV reg and MVN pass B through the ALU, so A is forced to zero.
    function automatic logic is_a_zero(input logic [2:0] opc, input logic [1:0] opf);
        return ((opc == 3'b110) && (opf == 2'b00)) || ((opc == 3'b101) && (opf == 2'b11));
    endfunction

    // Every encoding without a defined path out of DECODE.
    function automatic logic is_undef(input logic [2:0] opc, input logic [1:0] opf);
        logic defined;
        defined = ((opc == 3'b110) && ((opf == 2'b10) || (opf == 2'b00))) ||
                  (opc == 3'b101);
        return !defined;
    endfunction

    // Moore output decode for a given state and latched instruction fields.
    function automatic ctrl_t decode_ctrl(input state_t st, input logic [2:0] opc,
                                          input logic [1:0] opf);
        ctrl_t c;
        c = '0;
        case (st)
            S_WAIT: begin
                c.w = 1'b1;
            end
            S_DECODE: begin
                c.err = is_undef(opc, opf);
            end
            S_WRITE_IMM: begin
                c.nsel  = NSEL_RN;
                c.vsel  = 2'b10;
                c.write = 1'b1;
            end
            S_GET_A: begin
                c.nsel  = NSEL_RN;
                c.loada = 1'b1;
            end
            S_GET_B: begin
                c.nsel  = NSEL_RM;
                c.loadb = 1'b1;
            end
            S_ALU: begin
                c.asel = is_a_zero(opc, opf);
                if (is_cmp(opc, opf)) begin
                    c.loads = 1'b1;
                end else begin
                    c.loadc = 1'b1;
                end
            end
            S_WRITE_REG: begin
                c.nsel  = NSEL_RD;
                c.vsel  = 2'b00;
                c.write = 1'b1;
            end
            default: begin
                c.w = 1'b1;
            end
        endcase
        return c;
    endfunction

    // Capture opcode/op only on the start edge out of WAIT; hold otherwise.
    always_comb begin
        opc_d = opc_q;
        op_d  = op_q;
        if ((state_q == S_WAIT) && s) begin
            opc_d = opcode;
            op_d  = op;
        end else begin
            opc_d = opc_q;
            op_d  = op_q;
        end
    end

    // Next-state logic; decisions use only the latched fields.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT: begin
                if (s) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DECODE: begin
                case ({opc_q, op_q})
                    5'b110_10:                       state_d = S_WRITE_IMM;
                    5'b110_00, 5'b101_11:            state_d = S_GET_B;
                    5'b101_00, 5'b101_01, 5'b101_10: state_d = S_GET_A;
                    default:                         state_d = S_WAIT;
                endcase
            end
            S_WRITE_IMM: state_d = S_WAIT;
            S_GET_A:     state_d = S_GET_B;
            S_GET_B:     state_d = S_ALU;
            S_ALU: begin
                if (is_cmp(opc_q, op_q)) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_WRITE_REG;
                end
            end
            S_WRITE_REG: state_d = S_WAIT;
            default:     state_d = S_WAIT;
        endcase
    end

    // State, latched fields and registered control outputs; reset wins over decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_WAIT;
            opc_q   <= 3'b000;
            op_q    <= 2'b00;
            ctrl_q  <= decode_ctrl(S_WAIT, 3'b000, 2'b00);
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            op_q    <= op_d;
            ctrl_q  <= decode_ctrl(state_d, opc_d, op_d);
        end
    end

    assign w     = ctrl_q.w;
    assign nsel  = ctrl_q.nsel;
    assign loada = ctrl_q.loada;
    assign loadb = ctrl_q.loadb;
    assign loadc = ctrl_q.loadc;
    assign loads = ctrl_q.loads;
    assign asel  = ctrl_q.asel;
    assign bsel  = ctrl_q.bsel;
    assign vsel  = ctrl_q.vsel;
    assign write = ctrl_q.write;
    assign err   = ctrl_q.err;

endmodule

// File: tb/tb_srm_fsm_ctrl.sv
// Scoreboard bench for srm_fsm_ctrl. The driver applies inputs at the falling
// edge. A reference model, written as per-instruction step lists, then queues
// the output vector expected after the next rising edge. A monitor pops and
// compares that vector one time unit after each rising edge. It also checks
// the output invariants.
module tb_srm_fsm_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic [1:0] op = 2'b00;
    logic       w, loada, loadb, loadc, loads, asel, bsel, write, err;
    logic [2:0] nsel;
    logic [1:0] vsel;

    int n_vec = 0;
    int n_err = 0;

    // Vector layout: {w, nsel[2:0], loada, loadb, loadc, loads, asel, bsel, vsel[1:0], write, err}
    logic [13:0] exp_q[$];
    logic [13:0] m_seq[$];
    bit          m_in_wait = 1'b1;
    localparam logic [13:0] V_WAIT = {1'b1, 13'b0};

    srm_fsm_ctrl dut (
        .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
        .w(w), .nsel(nsel), .loada(loada), .loadb(loadb), .loadc(loadc),
        .loads(loads), .asel(asel), .bsel(bsel), .vsel(vsel),
        .write(write), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] v(input logic [2:0] ns, input logic la, input logic lb,
                                      input logic lc, input logic ls, input logic as_,
                                      input logic [1:0] vs, input logic wr, input logic er);
        return {1'b0, ns, la, lb, lc, ls, as_, 1'b0, vs, wr, er};
    endfunction

    // Expected cycle-by-cycle outputs of one instruction, from DECODE up to the return to WAIT.
    task automatic build(input logic [2:0] oc, input logic [1:0] o);
        logic [4:0] k;
        k = {oc, o};
        m_seq.delete();
        if (k == 5'b110_10) begin
            m_seq.push_back(v(3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0));
            m_seq.push_back(v(3'b001, 0, 0, 0, 0, 0, 2'b10, 1, 0));
        end else if (k == 5'b110_00 || k == 5'b101_11) begin
            m_seq.push_back(v(3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0));
            m_seq.push_back(v(3'b100, 0, 1, 0, 0, 0, 2'b00, 0, 0));
            m_seq.push_back(v(3'b000, 0, 0, 1, 0, 1, 2'b00, 0, 0));
            m_seq.push_back(v(3'b010, 0, 0, 0, 0, 0, 2'b00, 1, 0));
        end else if (k == 5'b101_00 || k == 5'b101_10) begin
            m_seq.push_back(v(3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0));
            m_seq.push_back(v(3'b001, 1, 0, 0, 0, 0, 2'b00, 0, 0));
            m_seq.push_back(v(3'b100, 0, 1, 0, 0, 0, 2'b00, 0, 0));
            m_seq.push_back(v(3'b000, 0, 0, 1, 0, 0, 2'b00, 0, 0));
            m_seq.push_back(v(3'b010, 0, 0, 0, 0, 0, 2'b00, 1, 0));
        end else if (k == 5'b101_01) begin
            m_seq.push_back(v(3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0));
            m_seq.push_back(v(3'b001, 1, 0, 0, 0, 0, 2'b00, 0, 0));
            m_seq.push_back(v(3'b100, 0, 1, 0, 0, 0, 2'b00, 0, 0));
            m_seq.push_back(v(3'b000, 0, 0, 0, 1, 0, 2'b00, 0, 0));
        end else begin
            m_seq.push_back(v(3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 1));
        end
    endtask

    // Reference model: predict the outputs after the coming rising edge.
    task automatic model_edge();
        logic [13:0] e;
        if (reset) begin
            m_seq.delete();
            m_in_wait = 1'b1;
            e = V_WAIT;
        end else if (m_in_wait) begin
            if (s) begin
                build(opcode, op);
                e = m_seq.pop_front();
                m_in_wait = 1'b0;
            end else begin
                e = V_WAIT;
            end
        end else if (m_seq.size() > 0) begin
            e = m_seq.pop_front();
        end else begin
            e = V_WAIT;
            m_in_wait = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic s_, input logic [2:0] oc, input logic [1:0] o);
        @(negedge clk);
        reset  = r;
        s      = s_;
        opcode = oc;
        op     = o;
        model_edge();
    endtask

    // Monitor: compare every presented output vector against the scoreboard.
    initial begin
        logic [13:0] e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, err};
                n_vec++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL outputs t=%0t actual=%b expected=%b", $time, a, e);
                end
                n_vec++;
                if ((write && (loada || loadb || loadc || loads)) ||
                    ($countones({loada, loadb, loadc, loads}) > 1) ||
                    !(nsel inside {3'b000, 3'b001, 3'b010, 3'b100})) begin
                    n_err++;
                    $display("FAIL invariant t=%0t actual=%b expected=exclusive enables, one-hot nsel", $time, a);
                end
            end
        end
    end

    // Stimulus: directed instruction sequences, then randomized traffic.
    initial begin
        logic [2:0] oc;
        logic [1:0] o;
        // reset state
        step(1, 0, 3'b000, 2'b00);
        step(1, 0, 3'b000, 2'b00);
        step(0, 0, 3'b000, 2'b00);
        // MOV R5,#85
        step(0, 1, 3'b110, 2'b10);
        repeat (4) step(0, 0, 3'b000, 2'b00);
        // ADD with opcode changed to 000 right after the start edge
        step(0, 1, 3'b101, 2'b00);
        repeat (7) step(0, 0, 3'b000, 2'b00);
        // CMP, MVN, MOV reg, AND
        step(0, 1, 3'b101, 2'b01);
        repeat (6) step(0, 0, 3'b111, 2'b11);
        step(0, 1, 3'b101, 2'b11);
        repeat (6) step(0, 0, 3'b000, 2'b00);
        step(0, 1, 3'b110, 2'b00);
        repeat (6) step(0, 0, 3'b000, 2'b00);
        step(0, 1, 3'b101, 2'b10);
        repeat (7) step(0, 0, 3'b000, 2'b00);
        // undefined encodings
        step(0, 1, 3'b111, 2'b00);
        repeat (3) step(0, 0, 3'b000, 2'b00);
        step(0, 1, 3'b110, 2'b01);
        repeat (3) step(0, 0, 3'b000, 2'b00);
        // back-to-back with s held high
        repeat (12) step(0, 1, 3'b110, 2'b10);
        repeat (3) step(0, 0, 3'b000, 2'b00);
        // reset while in GET_B of an ADD
        step(0, 1, 3'b101, 2'b00);
        step(0, 0, 3'b101, 2'b00);
        step(0, 0, 3'b101, 2'b00);
        step(1, 0, 3'b101, 2'b00);
        repeat (4) step(0, 0, 3'b000, 2'b00);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                oc = ($urandom_range(0, 1) == 0) ? 3'b101 : 3'b110;
            end else begin
                oc = 3'($urandom_range(0, 7));
            end
            o = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 79) == 0), ($urandom_range(0, 2) == 0), oc, o);
        end
        step(0, 0, 3'b000, 2'b00);
        // drain the scoreboard, bounded
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain actual=%0d pending expected=0 pending", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
